// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider bank.
package clk_div_pkg;

  // Default counter width and reset half-period for a 50 MHz board
  // (a 1 Hz square wave).
  localparam int CW_DEFAULT           = 27;
  localparam int DEFAULT_HALF_DEFAULT = 25000000;

  // A programmed half-period of zero behaves like one, so a channel can
  // never stall.
  function automatic logic [31:0] eff_half(input logic [31:0] half);
    return (half == 32'd0) ? 32'd1 : half;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active and pending half-period,
// registered square-wave and tick outputs.
//
// Reconfiguration: a written value waits in pend_half until the channel
// reaches a half-period boundary, a sync, or a disabled edge. The live
// half-period therefore never changes mid-half-period, and no runt pulses
// occur. While pending is high the top refuses further writes, so wr only
// arrives with pending low.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CW           = CW_DEFAULT,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEFAULT
) (
  input  logic          clki,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_half,
  output logic          clk_out,
  output logic          tick,
  output logic          pending
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] half;
  logic [CW-1:0] pend_half;
  logic [CW-1:0] heff;
  logic          boundary;

  // Effective half-period and the end-of-half-period detect.
  always_comb begin
    heff     = CW'(eff_half(32'(half)));
    boundary = (cnt == (heff - CW'(1)));
  end

  // Channel state. Priority: rst > sync > disabled > boundary > count.
  // A write is recorded last, so it also lands on a cycle that applies or
  // clears an older pending value.
  always_ff @(posedge clki) begin
    if (rst) begin
      cnt       <= '0;
      half      <= CW'(DEFAULT_HALF);
      pend_half <= CW'(DEFAULT_HALF);
      pending   <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      if (sync || !en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (pending) begin
          half    <= pend_half;
          pending <= 1'b0;
        end
      end else if (boundary) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
        if (pending) begin
          half    <= pend_half;
          pending <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
      if (wr) begin
        pend_half <= wr_half;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independently programmable clock dividers sharing one
// configuration port and one phase-alignment sync pulse.
//
// Config handshake: a transfer happens on a posedge where cfg_valid and
// cfg_ready are both high. cfg_ready is combinational from cfg_ch. It is low
// while the addressed channel holds an unapplied value. A cfg_ch beyond the
// last channel is always ready and the write is dropped. cfg_valid may be
// held across ready-low cycles without losing or duplicating the request.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int CW           = CW_DEFAULT,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEFAULT,
  localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clki,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           cfg_valid,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_half,
  output logic           cfg_ready,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] wr;

  // Ready mux: an unmatched (out-of-range) channel number stays ready.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CHW'(i)) cfg_ready = !pending[i];
    end
  end

  // Channel decode to per-channel write strobes, plus the channel array.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CHW'(g));

    clk_div_ch #(
      .CW           (CW),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clki    (clki),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_half (cfg_half),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank (NCH=4, CW=8, DEFAULT_HALF=5).
// Each scenario lists the edges at which every channel toggles. Those lists
// are expanded into per-edge expected {clk_out, tick} words on a queue, and
// the words are popped and compared edge by edge.
module tb_clk_div_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DH  = 5;

  logic           clki = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync;
  logic           cfg_valid;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_half;
  logic           cfg_ready;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  clk_div_bank #(.NCH(NCH), .CW(CW), .DEFAULT_HALF(DH)) dut (
    .clki      (clki),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // ---------------- clock / reset ----------------
  always #5 clki = ~clki;

  task automatic step();
    @(posedge clki);
    #1;
  endtask

  // After this, the next posedge is edge 1 with rst low.
  task automatic apply_reset();
    rst = 1'b1; en = '0; sync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- expectation model ----------------
  // {clk_out, tick} of one channel after edge k, given its toggle edges.
  function automatic logic [1:0] wave_at(input int k, input int tog[$]);
    int   n = 0;
    logic t = 1'b0;
    foreach (tog[i]) begin
      if (tog[i] <= k) n++;
      if (tog[i] == k) t = 1'b1;
    end
    return {n[0], t};
  endfunction

  task automatic push_waves(input int n, input int t0[$], input int t1[$],
                            input int t2[$], input int t3[$]);
    for (int k = 1; k <= n; k++) begin
      logic [1:0] w0, w1, w2, w3;
      w0 = wave_at(k, t0);
      w1 = wave_at(k, t1);
      w2 = wave_at(k, t2);
      w3 = wave_at(k, t3);
      exp_q.push_back({w3[1], w2[1], w1[1], w0[1], w3[0], w2[0], w1[0], w0[0]});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int none[$];
    int all5[$];
    logic [7:0] got, exp;
    all5.push_back(5);
    apply_reset();
    en = 4'hf;
    push_waves(6, all5, all5, all5, all5);
    for (int k = 1; k <= 6; k++) begin
      step();
      got = {clk_out, tick};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_run edge %0d: got %h want %h", k, got, exp);
      end
    end
    // Reset while all channels are high mid half-period.
    rst = 1'b1;
    step();
    total++;
    if ({clk_out, tick} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 00", {clk_out, tick});
    end
    for (int c = 0; c < NCH; c++) begin
      cfg_ch = 2'(c);
      #1;
      total++;
      if (cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_ready ch%0d: got %b want 1", c, cfg_ready);
      end
    end
    rst = 1'b0; en = '0; cfg_ch = '0;
    void'(none.size());
  endtask

  task automatic test_basic();
    int t0[$];
    int none[$];
    logic [7:0] got, exp;
    t0.push_back(5); t0.push_back(10);
    apply_reset();
    en = 4'b0001;
    push_waves(12, t0, none, none, none);
    for (int k = 1; k <= 12; k++) begin
      step();
      got = {clk_out, tick};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL basic edge %0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_reconfig();
    int t1[$];
    int none[$];
    logic [7:0] got, exp;
    logic       exp_rdy;
    t1.push_back(5); t1.push_back(8); t1.push_back(11); t1.push_back(14);
    apply_reset();
    en = 4'b0010;
    cfg_ch = 2'd1;
    cfg_half = 8'd3;
    push_waves(15, none, t1, none, none);
    for (int k = 1; k <= 15; k++) begin
      cfg_valid = (k == 2);
      step();
      got = {clk_out, tick};
      exp = exp_q.pop_front();
      exp_rdy = !(k >= 2 && k <= 4);
      total += 2;
      if (got !== exp) begin
        bad++;
        $display("FAIL reconfig edge %0d: got %h want %h", k, got, exp);
      end
      if (cfg_ready !== exp_rdy) begin
        bad++;
        $display("FAIL reconfig_ready edge %0d: got %b want %b", k, cfg_ready, exp_rdy);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t1[$];
    int none[$];
    logic [7:0] got, exp;
    logic       exp_rdy;
    t1.push_back(5); t1.push_back(8); t1.push_back(10);
    t1.push_back(12); t1.push_back(14);
    apply_reset();
    en = 4'b0010;
    cfg_ch = 2'd1;
    push_waves(14, none, t1, none, none);
    for (int k = 1; k <= 14; k++) begin
      cfg_valid = (k <= 6);
      cfg_half  = (k == 1) ? 8'd3 : 8'd2;
      step();
      got = {clk_out, tick};
      exp = exp_q.pop_front();
      exp_rdy = !((k >= 1 && k <= 4) || (k >= 6 && k <= 7));
      total += 2;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back edge %0d: got %h want %h", k, got, exp);
      end
      if (cfg_ready !== exp_rdy) begin
        bad++;
        $display("FAIL back_to_back_ready edge %0d: got %b want %b", k, cfg_ready, exp_rdy);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_half_zero();
    int t2[$];
    int none[$];
    logic [7:0] got, exp;
    logic       exp_rdy;
    for (int k = 3; k <= 8; k++) t2.push_back(k);
    apply_reset();
    cfg_ch = 2'd2;
    cfg_half = 8'd0;
    push_waves(8, none, none, t2, none);
    for (int k = 1; k <= 8; k++) begin
      cfg_valid = (k == 1);
      en = (k >= 3) ? 4'b0100 : 4'b0000;
      step();
      got = {clk_out, tick};
      exp = exp_q.pop_front();
      exp_rdy = (k != 1);
      total += 2;
      if (got !== exp) begin
        bad++;
        $display("FAIL half_zero edge %0d: got %h want %h", k, got, exp);
      end
      if (cfg_ready !== exp_rdy) begin
        bad++;
        $display("FAIL half_zero_ready edge %0d: got %b want %b", k, cfg_ready, exp_rdy);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_sync();
    int t0[$], t1[$], t3[$];
    logic [7:0] got, exp;
    logic       exp_rdy;
    t0.push_back(9); t0.push_back(11); t0.push_back(13); t0.push_back(15);
    t1.push_back(10); t1.push_back(13); t1.push_back(16);
    t3.push_back(11); t3.push_back(15);
    apply_reset();
    push_waves(16, t0, t1, t1, t3);
    for (int k = 1; k <= 16; k++) begin
      cfg_valid = (k <= 3) || (k == 5);
      cfg_ch    = (k == 1) ? 2'd1 : (k == 2) ? 2'd2 : (k == 3) ? 2'd3 : 2'd0;
      cfg_half  = (k <= 2) ? 8'd3 : (k == 3) ? 8'd4 : 8'd2;
      en        = (k >= 5) ? 4'hf : 4'h0;
      sync      = (k == 7);
      step();
      got = {clk_out, tick};
      exp = exp_q.pop_front();
      exp_rdy = !(k <= 3 || k == 5 || k == 6);
      total += 2;
      if (got !== exp) begin
        bad++;
        $display("FAIL sync edge %0d: got %h want %h", k, got, exp);
      end
      if (cfg_ready !== exp_rdy) begin
        bad++;
        $display("FAIL sync_ready edge %0d: got %b want %b", k, cfg_ready, exp_rdy);
      end
    end
    cfg_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic test_reset_pending();
    int t0[$];
    int none[$];
    logic [7:0] got, exp;
    logic       exp_rdy;
    t0.push_back(8); t0.push_back(13);
    apply_reset();
    en = 4'b0001;
    cfg_ch = 2'd0;
    cfg_half = 8'd2;
    push_waves(15, t0, none, none, none);
    for (int k = 1; k <= 15; k++) begin
      cfg_valid = (k == 1);
      rst       = (k == 3);
      step();
      got = {clk_out, tick};
      exp = exp_q.pop_front();
      exp_rdy = !(k == 1 || k == 2);
      total += 2;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_pending edge %0d: got %h want %h", k, got, exp);
      end
      if (cfg_ready !== exp_rdy) begin
        bad++;
        $display("FAIL reset_pending_ready edge %0d: got %b want %b", k, cfg_ready, exp_rdy);
      end
    end
    rst = 1'b0; cfg_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_reconfig();
    test_back_to_back();
    test_half_zero();
    test_sync();
    test_reset_pending();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
